// File: rtl/ysyx_25040111_bru_pkg.sv
// rtl/ysyx_25040111_bru_pkg.sv - shared constants and types for the branch resolution unit
package ysyx_25040111_bru_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    // Branch control field positions, matching the decoder's EQUAL/COMPARE
    // (cmp) and EXX/EXN/ESX/ESN (sgn, neg) encodings.
    localparam int CTL_NEG = 0;
    localparam int CTL_SGN = 1;
    localparam int CTL_CMP = 2;
    localparam int CTL_W   = 3;

    // Resolved branch flags carried from S1 into the result register.
    typedef struct packed {
        logic taken;
        logic mispred;
        logic misalign;
    } br_flags_t;

    function automatic logic [CTL_W-1:0] pack_ctl(input logic cmp, input logic sgn, input logic neg);
        logic [CTL_W-1:0] ctl;
        ctl          = '0;
        ctl[CTL_CMP] = cmp;
        ctl[CTL_SGN] = sgn;
        ctl[CTL_NEG] = neg;
        return ctl;
    endfunction

endpackage

// File: rtl/ysyx_25040111_bru_cmp.sv
// rtl/ysyx_25040111_bru_cmp.sv - combinational branch condition evaluator
module ysyx_25040111_bru_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            cmp,
    input  logic            sgn,
    input  logic            neg,
    output logic            cond
);

    logic eq;
    logic lt;

    // Equality or (un)signed less-than, optionally inverted for bne/bge/bgeu.
    always_comb begin
        eq   = (src1 == src2);
        lt   = sgn ? ($signed(src1) < $signed(src2)) : (src1 < src2);
        cond = (cmp ? lt : eq) ^ neg;
    end

endmodule

// File: rtl/ysyx_25040111_bru.sv
// rtl/ysyx_25040111_bru.sv - two-stage branch resolution unit with redirect and counters
module ysyx_25040111_bru
    import ysyx_25040111_bru_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_cmp,
    input  logic             in_sgn,
    input  logic             in_neg,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_npc,
    output logic             out_mispred,
    output logic             out_misalign,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_mispred
);

    logic             s1_v;
    logic [XLEN-1:0]  s1_pc;
    logic [XLEN-1:0]  s1_src1;
    logic [XLEN-1:0]  s1_src2;
    logic [XLEN-1:0]  s1_imm;
    logic [CTL_W-1:0] s1_ctl;
    logic             s1_pred;

    logic             s2_v;
    br_flags_t        s2_flags;

    logic             s2_rdy;
    logic             s1_rdy;
    logic             in_fire;
    logic             out_fire;
    logic             kill;
    logic             s1_adv;

    logic             s1_cond;
    logic [XLEN-1:0]  s1_target;
    logic [XLEN-1:0]  s1_fall;
    logic [XLEN-1:0]  s1_npc;
    br_flags_t        s1_flags;

    // A mispredicted result retiring kills the younger op still in S1 and
    // blocks intake for that cycle; flush overrides everything.
    assign s2_rdy   = !s2_v || out_ready;
    assign s1_rdy   = !s1_v || s2_rdy;
    assign out_fire = s2_v && out_ready;
    assign kill     = out_fire && s2_flags.mispred;
    assign in_ready = s1_rdy && !flush && !kill;
    assign in_fire  = in_valid && in_ready;
    assign s1_adv   = s1_v && s2_rdy && !kill && !flush;

    assign out_valid    = s2_v;
    assign out_taken    = s2_flags.taken;
    assign out_mispred  = s2_flags.mispred;
    assign out_misalign = s2_flags.misalign;

    ysyx_25040111_bru_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .src1 (s1_src1),
        .src2 (s1_src2),
        .cmp  (s1_ctl[CTL_CMP]),
        .sgn  (s1_ctl[CTL_SGN]),
        .neg  (s1_ctl[CTL_NEG]),
        .cond (s1_cond)
    );

    assign s1_target = s1_pc + s1_imm;
    assign s1_fall   = s1_pc + XLEN'(4);
    assign s1_npc    = s1_cond ? s1_target : s1_fall;

    // Resolve direction; a misaligned taken target traps instead of redirecting.
    always_comb begin
        s1_flags          = '0;
        s1_flags.taken    = s1_cond;
        s1_flags.misalign = s1_cond && (s1_target[1:0] != 2'b00);
        s1_flags.mispred  = (s1_cond != s1_pred) && !(s1_cond && (s1_target[1:0] != 2'b00));
    end

    // S1 operand register: captures the decoded op on input handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s1_pc   <= '0;
            s1_src1 <= '0;
            s1_src2 <= '0;
            s1_imm  <= '0;
            s1_ctl  <= '0;
            s1_pred <= 1'b0;
        end else begin
            if (flush || kill) begin
                s1_v <= 1'b0;
            end else if (in_fire) begin
                s1_v <= 1'b1;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            if (in_fire) begin
                s1_pc   <= in_pc;
                s1_src1 <= in_src1;
                s1_src2 <= in_src2;
                s1_imm  <= in_imm;
                s1_ctl  <= pack_ctl(in_cmp, in_sgn, in_neg);
                s1_pred <= in_pred_taken;
            end
        end
    end

    // S2 result register: holds the resolved branch until the consumer takes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_v     <= 1'b0;
            s2_flags <= '0;
            out_pc   <= '0;
            out_npc  <= '0;
        end else begin
            if (flush) begin
                s2_v <= 1'b0;
            end else if (s1_adv) begin
                s2_v <= 1'b1;
            end else if (out_fire) begin
                s2_v <= 1'b0;
            end
            if (s1_adv) begin
                s2_flags <= s1_flags;
                out_pc   <= s1_pc;
                out_npc  <= s1_npc;
            end
        end
    end

    // Registered one-cycle redirect following a kill, suppressed by flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= kill && !flush;
            if (kill && !flush) begin
                redirect_pc <= out_npc;
            end
        end
    end

    // Wrapping performance counters, advanced only by retiring results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_branch  <= '0;
            cnt_taken   <= '0;
            cnt_mispred <= '0;
        end else if (out_fire) begin
            cnt_branch  <= cnt_branch + CNT_W'(1);
            cnt_taken   <= cnt_taken + CNT_W'(s2_flags.taken);
            cnt_mispred <= cnt_mispred + CNT_W'(s2_flags.mispred);
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_bru.sv
// tb/tb_ysyx_25040111_bru.sv - scoreboard testbench for the branch resolution unit
module tb_ysyx_25040111_bru;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        pred;
    } op_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        taken;
        logic        mispred;
        logic        misalign;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_cmp = 1'b0;
    logic        in_sgn = 1'b0;
    logic        in_neg = 1'b0;
    logic        in_pred_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic        out_taken;
    logic [31:0] out_npc;
    logic        out_mispred;
    logic        out_misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] cnt_branch;
    logic [31:0] cnt_taken;
    logic [31:0] cnt_mispred;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors = 0;
    int unsigned m_br = 0;
    int unsigned m_tk = 0;
    int unsigned m_mp = 0;
    logic        exp_rd = 1'b0;
    logic [31:0] exp_rd_pc = '0;

    ysyx_25040111_bru dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_src1        (in_src1),
        .in_src2        (in_src2),
        .in_imm         (in_imm),
        .in_cmp         (in_cmp),
        .in_sgn         (in_sgn),
        .in_neg         (in_neg),
        .in_pred_taken  (in_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_taken      (out_taken),
        .out_npc        (out_npc),
        .out_mispred    (out_mispred),
        .out_misalign   (out_misalign),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .cnt_branch     (cnt_branch),
        .cnt_taken      (cnt_taken),
        .cnt_mispred    (cnt_mispred)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu
    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic        c;
        logic [31:0] tgt;
        case (o.kind)
            3'd0:    c = (o.a == o.b);
            3'd1:    c = (o.a != o.b);
            3'd2:    c = ($signed(o.a) < $signed(o.b));
            3'd3:    c = ($signed(o.a) >= $signed(o.b));
            3'd4:    c = (o.a < o.b);
            3'd5:    c = (o.a >= o.b);
            default: c = 1'b0;
        endcase
        tgt        = o.pc + o.imm;
        e.pc       = o.pc;
        e.taken    = c;
        e.npc      = c ? tgt : o.pc + 32'd4;
        e.misalign = c && (tgt[1:0] != 2'b00);
        e.mispred  = (c != o.pred) && !e.misalign;
        return e;
    endfunction

    function automatic op_t mk(input int kind, input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm, input logic pred);
        op_t o;
        o.kind = 3'(kind);
        o.pc   = pc;
        o.a    = a;
        o.b    = b;
        o.imm  = imm;
        o.pred = pred;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t         o;
        logic [31:0] r;
        o.kind = 3'($urandom_range(0, 5));
        o.pc   = $urandom & 32'hFFFF_FFFC;
        case ($urandom_range(0, 2))
            0:       begin o.a = 32'($urandom_range(0, 3)) - 32'd1; o.b = 32'($urandom_range(0, 3)) - 32'd1; end
            1:       begin o.a = $urandom; o.b = $urandom; end
            default: begin o.a = $urandom; o.b = o.a; end
        endcase
        r     = $urandom;
        o.imm = {{19{r[12]}}, r[12:2], ($urandom_range(0, 7) == 0), 1'b0};
        o.pred = 1'($urandom_range(0, 1));
        return o;
    endfunction

    task automatic apply(input op_t o);
        in_pc         = o.pc;
        in_src1       = o.a;
        in_src2       = o.b;
        in_imm        = o.imm;
        in_cmp        = (o.kind >= 3'd2);
        in_sgn        = (o.kind == 3'd2) || (o.kind == 3'd3);
        in_neg        = o.kind[0];
        in_pred_taken = o.pred;
    endtask

    // Present one op for one cycle; entered and left at posedge+1.
    task automatic offer(input op_t o, output bit acc);
        apply(o);
        in_valid = 1'b1;
        @(negedge clock);
        acc = in_ready;
        if (acc) sb.push_back(model(o));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input op_t o);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            offer(o, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Monitor: checks outputs against the scoreboard head, counters and redirect.
    always @(negedge clock) begin
        exp_t e;
        logic nxt_rd;
        if (reset) begin
            sb.delete();
            m_br   = 0;
            m_tk   = 0;
            m_mp   = 0;
            exp_rd = 1'b0;
        end else begin
            nxt_rd = 1'b0;
            chk("redirect_valid", 32'(redirect_valid), 32'(exp_rd));
            if (exp_rd) chk("redirect_pc", redirect_pc, exp_rd_pc);
            chk("cnt_branch", cnt_branch, m_br);
            chk("cnt_taken", cnt_taken, m_tk);
            chk("cnt_mispred", cnt_mispred, m_mp);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_pc", out_pc, 32'hDEAD_BEEF);
                end else begin
                    e = sb[0];
                    chk("out_pc", out_pc, e.pc);
                    chk("out_npc", out_npc, e.npc);
                    chk("out_flags", {29'd0, out_taken, out_mispred, out_misalign},
                        {29'd0, e.taken, e.mispred, e.misalign});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        m_br++;
                        if (e.taken) m_tk++;
                        if (e.mispred) m_mp++;
                        if (e.mispred && !flush) begin
                            nxt_rd    = 1'b1;
                            exp_rd_pc = e.npc;
                            sb.delete();
                        end
                    end
                end
            end
            if (flush) sb.delete();
            exp_rd = nxt_rd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        op_t ops[4];
        op_t a_op;
        op_t b_op;
        bit  acc;
        int  acc_n;
        int unsigned base;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_out_npc", out_npc, 32'd0);
        chk("rst_cnt_branch", cnt_branch, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // beq taken, predicted not-taken: mispredict and redirect
        send(mk(0, 32'h8000_0000, 32'd5, 32'd5, 32'h10, 1'b0));
        drain();
        chk("t1_cnt_mispred", cnt_mispred, 32'd1);
        chk("t1_redirect_pc", redirect_pc, 32'h8000_0010);

        // signed vs unsigned compares, correctly predicted
        send(mk(2, 32'h0000_1000, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1));
        send(mk(4, 32'h0000_2000, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0));
        send(mk(3, 32'h0000_3000, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0));
        send(mk(5, 32'h0000_4000, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1));
        drain();

        // misaligned taken target traps instead of redirecting
        send(mk(0, 32'h8000_0000, 32'd7, 32'd7, 32'h6, 1'b0));
        drain();

        // backpressure: only two ops fit while the consumer stalls
        for (int i = 0; i < 4; i++) begin
            ops[i] = mk(i, 32'h100 + 32'(i) * 32'h10, 32'(i), 32'd2, 32'h40, 1'b0);
            ops[i].pred = model(ops[i]).taken;
        end
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            offer(ops[acc_n], acc);
            if (acc) acc_n++;
            if (acc_n == 4) break;
        end
        chk("bp_accepted", 32'(acc_n), 32'd2);
        base = m_br;
        out_ready = 1'b1;
        send(ops[2]);
        send(ops[3]);
        drain();
        chk("bp_cnt_branch", cnt_branch, base + 32'd4);

        // kill: mispredict in S2 drops the younger op in S1 and blocks intake
        a_op = mk(1, 32'h200, 32'd1, 32'd2, 32'h80, 1'b0);
        b_op = mk(0, 32'h204, 32'd3, 32'd3, 32'h8, 1'b1);
        out_ready = 1'b0;
        send(a_op);
        send(b_op);
        base = m_br;
        out_ready = 1'b1;
        offer(b_op, acc);
        chk("kill_in_ready", {31'd0, acc}, 32'd0);
        drain();
        chk("kill_cnt_branch", cnt_branch, base + 32'd1);

        // flush with both stages full and a mispredict retiring
        out_ready = 1'b0;
        send(a_op);
        send(b_op);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
        @(posedge clock);
        #1;

        // random traffic with backpressure and occasional flush
        for (int c = 0; c < 600; c++) begin
            op_t o;
            o = rnd_op();
            apply(o);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (in_valid && in_ready) sb.push_back(model(o));
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            flush    = 1'b0;
        end
        drain();

        // asynchronous reset in the middle of traffic
        out_ready = 1'b0;
        send(rnd_op());
        send(rnd_op());
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_pc", out_pc, 32'd0);
        chk("arst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        chk("arst_cnt_branch", cnt_branch, 32'd0);
        chk("arst_cnt_taken", cnt_taken, 32'd0);
        chk("arst_cnt_mispred", cnt_mispred, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(mk(2, 32'h300, 32'h8000_0000, 32'd0, 32'h100, 1'b1));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
